// File: rtl/syn_load_arbiter.sv
// syn_load_arbiter: round-robin arbiter that sequences loads into one shared
// synchronous-load register. One requester is granted at a time, the register
// load/data pins are driven for exactly one cycle, then the winner is acked.
// A programmable idle gap separates consecutive services.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for any req; winner and its data captured on grant
//   LOAD   | load=1 for one cycle, shared register captures load_data
//   ACK    | ack[grant_id]=1 for one cycle, rr pointer advances
//   GAP    | GAP_CYCLES idle cycles, req ignored (skipped when 0)
module syn_load_arbiter #(
  parameter int NREQ       = 4,
  parameter int W          = 4,
  parameter int GAP_CYCLES = 1,
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              load,
  output logic [W-1:0]      load_data,
  output logic [IW-1:0]     grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ACK  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] rr_adv;
  logic [IW-1:0] winner;
  logic [W-1:0]  winner_data;
  logic          any_req;
  logic [3:0]    gap_cnt;

  // Winner search: first set req at or above rr_ptr, otherwise first set req
  // below it (wrap). Constant loop indices keep the data mux simple.
  always_comb begin
    winner      = '0;
    winner_data = '0;
    any_req     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && req[i] && (IW'(i) >= rr_ptr)) begin
        any_req     = 1'b1;
        winner      = IW'(i);
        winner_data = req_data[i*W +: W];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && req[i]) begin
        any_req     = 1'b1;
        winner      = IW'(i);
        winner_data = req_data[i*W +: W];
      end
    end
  end

  // Pointer moves to the requester just after the one being acked.
  always_comb begin
    rr_adv = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
  end

  // Next-state and output decode; load/ack/busy are pure functions of state.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    ack        = '0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (any_req) state_next = S_LOAD;
      end
      S_LOAD: begin
        load       = 1'b1;
        state_next = S_ACK;
      end
      S_ACK: begin
        ack[grant_id] = 1'b1;
        state_next    = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        // Terminal count: the cycle where the counter would step to zero.
        if (gap_cnt <= 4'd1) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, grant capture, rr pointer and gap down-counter; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
      grant_id  <= '0;
      load_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_id  <= winner;
            load_data <= winner_data;
          end
        end
        S_ACK: begin
          rr_ptr  <= rr_adv;
          gap_cnt <= GAP_INIT;
        end
        S_GAP: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_load_arbiter.sv
// Bench for syn_load_arbiter: one instance with a 1-cycle gap, one with no gap.
// Expected grants are queued when requests are driven and popped on each load.
module tb_syn_load_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic        load;
  logic [3:0]  load_data;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  req0;
  logic [15:0] rd0;
  logic [3:0]  ack0;
  logic        load0;
  logic [3:0]  ld0;
  logic [1:0]  gid0;
  logic        busy0;

  logic [3:0]  shadow;
  exp_t        sb[$];
  exp_t        sb0[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Model of the shared register the arbiter feeds.
  always @(posedge clk) if (load) shadow <= load_data;

  syn_load_arbiter #(.NREQ(4), .W(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .load(load), .load_data(load_data), .grant_id(grant_id), .busy(busy));

  syn_load_arbiter #(.NREQ(4), .W(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .req_data(rd0), .ack(ack0),
    .load(load0), .load_data(ld0), .grant_id(gid0), .busy(busy0));

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; req = 4'hF; req_data = 16'hFCA2; req0 = 4'h0; rd0 = 16'h7003;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++; if ({load, ack, busy, load_data} !== 10'b0) begin n_err++;
        $display("FAIL reset_outputs: load=%b ack=%b busy=%b load_data=%h, want all 0", load, ack, busy, load_data); end
    end
    rst = 1'b0;
    sb.push_back('{2'd0, 4'h2});
    @(negedge clk);
    n_vec++; if (load !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL reset_first_load: load=%b want 1", load); end
    else begin e = sb.pop_front(); n_vec++;
      if (grant_id !== e.id || load_data !== e.data) begin n_err++;
        $display("FAIL reset_first_grant: id=%0d data=%h want id=%0d data=%h", grant_id, load_data, e.id, e.data); end end
    req = 4'h0;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL reset_ack: ack=%b want 0001", ack); end
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_single();
    exp_t e;
    req = 4'b0100; req_data = 16'h0A00;
    sb.push_back('{2'd2, 4'hA});
    @(negedge clk);
    n_vec++; if (load !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL single_load: load=%b want 1", load); end
    else begin e = sb.pop_front(); n_vec++;
      if (grant_id !== e.id || load_data !== e.data) begin n_err++;
        $display("FAIL single_data: id=%0d data=%h want id=%0d data=%h", grant_id, load_data, e.id, e.data); end end
    req = 4'h0;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0100 || load !== 1'b0) begin n_err++; $display("FAIL single_ack: ack=%b load=%b want 0100/0", ack, load); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b1 || ack !== 4'b0) begin n_err++; $display("FAIL single_gap: busy=%b ack=%b want 1/0000", busy, ack); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int loads = 0;
    int last = 0;
    logic [3:0] exp_ack = 4'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_data = 16'hFCA2; req = 4'hF;
    sb.push_back('{2'd0, 4'h2}); sb.push_back('{2'd1, 4'hA}); sb.push_back('{2'd2, 4'hC});
    sb.push_back('{2'd3, 4'hF}); sb.push_back('{2'd0, 4'h2});
    for (int cyc = 0; cyc < 40 && loads < 5; cyc++) begin
      @(negedge clk);
      n_vec++; if (ack !== exp_ack) begin n_err++; $display("FAIL rr_ack: ack=%b want %b", ack, exp_ack); end
      exp_ack = 4'b0;
      if (load === 1'b1) begin
        if (sb.size() == 0) begin n_vec++; n_err++; $display("FAIL rr_extra_load: id=%0d", grant_id); end
        else begin e = sb.pop_front(); n_vec++;
          if (grant_id !== e.id || load_data !== e.data) begin n_err++;
            $display("FAIL rr_data: id=%0d data=%h want id=%0d data=%h", grant_id, load_data, e.id, e.data); end
          exp_ack = 4'b0001 << e.id; end
        if (loads > 0) begin n_vec++;
          if (cyc - last != 4) begin n_err++; $display("FAIL rr_interval: %0d cycles want 4", cyc - last); end end
        last = cyc; loads++;
        if (loads == 5) req = 4'h0;
      end
    end
    n_vec++; if (loads != 5) begin n_err++; $display("FAIL rr_timeout: %0d loads want 5", loads); end
    @(negedge clk);
    n_vec++; if (ack !== exp_ack) begin n_err++; $display("FAIL rr_last_ack: ack=%b want %b", ack, exp_ack); end
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_capture();
    exp_t e;
    req = 4'b0010; req_data = 16'h0050;
    sb.push_back('{2'd1, 4'h5});
    @(negedge clk);
    n_vec++; if (load !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL cap_load: load=%b want 1", load); end
    else begin e = sb.pop_front(); n_vec++;
      if (grant_id !== e.id || load_data !== e.data) begin n_err++;
        $display("FAIL cap_data: id=%0d data=%h want id=%0d data=%h", grant_id, load_data, e.id, e.data); end end
    req_data = 16'h00C0;
    @(negedge clk);
    n_vec++; if (shadow !== 4'h5) begin n_err++; $display("FAIL cap_reg: reg=%h want 5", shadow); end
    n_vec++; if (ack !== 4'b0010) begin n_err++; $display("FAIL cap_ack: ack=%b want 0010", ack); end
    req = 4'h0;
    @(negedge clk);
    @(negedge clk);
    req = 4'b0100; req_data = 16'h0600;
    sb.push_back('{2'd2, 4'h6});
    @(negedge clk);
    n_vec++; if (load !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL drop_load: load=%b want 1", load); end
    else begin e = sb.pop_front(); n_vec++;
      if (grant_id !== e.id || load_data !== e.data) begin n_err++;
        $display("FAIL drop_data: id=%0d data=%h want id=%0d data=%h", grant_id, load_data, e.id, e.data); end end
    req = 4'h0;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0100) begin n_err++; $display("FAIL drop_ack: ack=%b want 0100", ack); end
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || load !== 1'b0) begin n_err++; $display("FAIL drop_idle: busy=%b load=%b want 0/0", busy, load); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    req = 4'b0001; req_data = 16'h0009;
    sb.push_back('{2'd0, 4'h9});
    @(negedge clk);
    n_vec++; if (load !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL mid_load: load=%b want 1", load); end
    else begin e = sb.pop_front(); n_vec++;
      if (grant_id !== e.id || load_data !== e.data) begin n_err++;
        $display("FAIL mid_data: id=%0d data=%h want id=%0d data=%h", grant_id, load_data, e.id, e.data); end end
    rst = 1'b1; req = 4'h0;
    @(negedge clk);
    n_vec++; if ({load, ack, busy, load_data, grant_id} !== 12'b0) begin n_err++;
      $display("FAIL mid_reset: load=%b ack=%b busy=%b data=%h id=%0d want all 0", load, ack, busy, load_data, grant_id); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_no_ack: ack=%b busy=%b want 0000/0", ack, busy); end
    req = 4'b1010; req_data = 16'hB0D0;
    sb.push_back('{2'd1, 4'hD});
    @(negedge clk);
    n_vec++; if (load !== 1'b1 || sb.size() == 0) begin n_err++; $display("FAIL mid_ptr_load: load=%b want 1", load); end
    else begin e = sb.pop_front(); n_vec++;
      if (grant_id !== e.id || load_data !== e.data) begin n_err++;
        $display("FAIL mid_ptr: id=%0d data=%h want id=%0d data=%h", grant_id, load_data, e.id, e.data); end end
    req = 4'h0;
    @(negedge clk);
    n_vec++; if (ack !== 4'b0010) begin n_err++; $display("FAIL mid_ptr_ack: ack=%b want 0010", ack); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int loads = 0;
    int last = 0;
    logic [3:0] exp_ack = 4'b0;
    req0 = 4'b1001; rd0 = 16'h7003;
    sb0.push_back('{2'd0, 4'h3}); sb0.push_back('{2'd3, 4'h7});
    sb0.push_back('{2'd0, 4'h3}); sb0.push_back('{2'd3, 4'h7});
    for (int cyc = 0; cyc < 30 && loads < 4; cyc++) begin
      @(negedge clk);
      n_vec++; if (ack0 !== exp_ack) begin n_err++; $display("FAIL b2b_ack: ack=%b want %b", ack0, exp_ack); end
      exp_ack = 4'b0;
      if (load0 === 1'b1) begin
        if (sb0.size() == 0) begin n_vec++; n_err++; $display("FAIL b2b_extra_load: id=%0d", gid0); end
        else begin e = sb0.pop_front(); n_vec++;
          if (gid0 !== e.id || ld0 !== e.data) begin n_err++;
            $display("FAIL b2b_data: id=%0d data=%h want id=%0d data=%h", gid0, ld0, e.id, e.data); end
          exp_ack = 4'b0001 << e.id; end
        if (loads > 0) begin n_vec++;
          if (cyc - last != 3) begin n_err++; $display("FAIL b2b_interval: %0d cycles want 3", cyc - last); end end
        last = cyc; loads++;
        if (loads == 4) req0 = 4'h0;
      end
    end
    n_vec++; if (loads != 4) begin n_err++; $display("FAIL b2b_timeout: %0d loads want 4", loads); end
    @(negedge clk);
    n_vec++; if (ack0 !== exp_ack) begin n_err++; $display("FAIL b2b_last_ack: ack=%b want %b", ack0, exp_ack); end
    @(negedge clk);
    n_vec++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL b2b_idle: busy=%b want 0", busy0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_capture();
    test_reset_mid();
    test_back_to_back();
    n_vec++; if (sb.size() != 0 || sb0.size() != 0) begin n_err++;
      $display("FAIL sb_drain: %0d/%0d entries left want 0", sb.size(), sb0.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
